// File: rtl/fios_job_arbiter.sv
// fios_job_arbiter: round-robin job arbiter sequencing one shared FIOS core.
// Ports: clock_i/reset_i, req_valid_i/req_ready_o handshake, core strobes
// (b/p fetch, res push, done) mapped to operand/result RAM controls,
// plus grant_id_o, busy_o, a_load_o, fios_start_o, job_done_o, err_o.
module fios_job_arbiter #(
  parameter int s       = 8,
  parameter int REQ_NB  = 2,
  parameter int TIMEOUT = 4096,
  localparam int IW = ($clog2(REQ_NB) < 1) ? 1 : $clog2(REQ_NB),
  localparam int AW = ($clog2(s) < 1) ? 1 : $clog2(s)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [REQ_NB-1:0] req_valid_i,
  output logic [REQ_NB-1:0] req_ready_o,
  output logic [IW-1:0]     grant_id_o,
  output logic              busy_o,
  output logic              a_load_o,
  output logic              fios_start_o,
  input  logic              b_fetch_i,
  input  logic              p_fetch_i,
  output logic              b_rd_en_o,
  output logic              p_rd_en_o,
  output logic [AW-1:0]     b_addr_o,
  output logic [AW-1:0]     p_addr_o,
  input  logic              res_push_i,
  output logic              res_we_o,
  output logic [AW-1:0]     res_addr_o,
  input  logic              done_i,
  output logic [REQ_NB-1:0] job_done_o,
  output logic              err_o
);

  localparam int CW = $clog2(s + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_COMPLETE
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_grant;
  logic [IW-1:0]     r_rr;
  logic              r_busy;
  logic              r_a_load;
  logic              r_start;
  logic              r_err_flag;
  logic              r_err;
  logic [REQ_NB-1:0] r_job_done;
  logic [AW-1:0]     r_b_addr;
  logic [AW-1:0]     r_p_addr;
  logic [AW-1:0]     r_res_addr;
  logic [CW-1:0]     r_pcnt;
  logic [TW-1:0]     r_to;

  logic              w_found;
  logic [IW-1:0]     w_win;
  int                w_idx;
  logic              w_idle;
  logic              w_run;
  logic              w_b_en;
  logic              w_p_en;
  logic              w_full;
  logic              w_we;
  logic              w_over;
  logic [CW-1:0]     w_pcnt_nxt;

  // First valid requester searching upward from r_rr, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int i = 0; i < REQ_NB; i++) begin
      w_idx = (int'(r_rr) + i) % REQ_NB;
      if (!w_found && req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
      end
    end
  end

  assign w_idle = (r_state == S_IDLE);
  assign w_run  = (r_state == S_RUN);
  assign w_b_en = w_run & b_fetch_i;
  assign w_p_en = w_run & p_fetch_i;
  assign w_full = (r_pcnt == CW'(s));
  assign w_we   = w_run & res_push_i & ~w_full;
  assign w_over = w_run & res_push_i & w_full;
  assign w_pcnt_nxt = r_pcnt + CW'(w_we);

  // Gated by reset so the handshake is dead while reset is held.
  assign req_ready_o = (w_idle && w_found && reset_i)
                     ? (REQ_NB'(1) << w_win) : '0;

  assign grant_id_o   = r_grant;
  assign busy_o       = r_busy;
  assign a_load_o     = r_a_load;
  assign fios_start_o = r_start;
  assign b_rd_en_o    = w_b_en;
  assign p_rd_en_o    = w_p_en;
  assign b_addr_o     = r_b_addr;
  assign p_addr_o     = r_p_addr;
  assign res_we_o     = w_we;
  assign res_addr_o   = r_res_addr;
  assign job_done_o   = r_job_done;
  assign err_o        = r_err;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_rr       <= '0;
      r_busy     <= 1'b0;
      r_a_load   <= 1'b0;
      r_start    <= 1'b0;
      r_err_flag <= 1'b0;
      r_err      <= 1'b0;
      r_job_done <= '0;
      r_b_addr   <= '0;
      r_p_addr   <= '0;
      r_res_addr <= '0;
      r_pcnt     <= '0;
      r_to       <= '0;
    end else begin
      r_a_load   <= 1'b0;
      r_start    <= 1'b0;
      r_job_done <= '0;
      r_err      <= 1'b0;

      if (w_b_en) begin
        r_b_addr <= (r_b_addr == AW'(s - 1)) ? '0 : r_b_addr + 1'b1;
      end
      if (w_p_en) begin
        r_p_addr <= (r_p_addr == AW'(s - 1)) ? '0 : r_p_addr + 1'b1;
      end
      if (w_we) begin
        r_pcnt <= w_pcnt_nxt;
        if (r_res_addr != AW'(s - 1)) begin
          r_res_addr <= r_res_addr + 1'b1;
        end
      end
      if (w_over) begin
        r_err_flag <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_LOAD;
            r_grant    <= w_win;
            r_busy     <= 1'b1;
            r_a_load   <= 1'b1;
            r_b_addr   <= '0;
            r_p_addr   <= '0;
            r_res_addr <= '0;
            r_pcnt     <= '0;
            r_err_flag <= 1'b0;
          end
        end
        S_LOAD: begin
          r_state <= S_START;
          r_start <= 1'b1;
        end
        S_START: begin
          // Counts the start cycle, so COMPLETE lands TIMEOUT cycles
          // after the start pulse.
          r_state <= S_RUN;
          r_to    <= TW'(1);
        end
        S_RUN: begin
          if (done_i) begin
            // Same-cycle push is already folded into w_pcnt_nxt.
            r_state    <= S_COMPLETE;
            r_job_done <= REQ_NB'(1) << r_grant;
            r_err      <= r_err_flag | w_over
                        | (w_pcnt_nxt != CW'(s));
          end else if (r_to == TW'(TIMEOUT - 1)) begin
            r_state    <= S_COMPLETE;
            r_job_done <= REQ_NB'(1) << r_grant;
            r_err      <= 1'b1;
            r_err_flag <= 1'b1;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        S_COMPLETE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_rr    <= (r_grant == IW'(REQ_NB - 1))
                   ? '0 : r_grant + 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
